demux5_buf: RTL and testbench

//  One-to-five steering buffer; the inverse of the 5-way select mux in the datapath.
//  A single producer offers one WIDTH-bit word with a 3-bit destination select.
//  The word is written into one of five single-entry holding slots.

---
 rtl/demux5_buf.sv | 94 +++++++++
 tb/tb_demux5_buf.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux5_buf.sv
// One-to-five steering buffer: a single producer word is steered into one of
// five single-entry slots, each drained independently through a valid/ack pair.
module demux5_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             demux5_valid,
  input  logic [WIDTH-1:0] demux5_d,
  input  logic [2:0]       demux5_s,
  output logic             demux5_ready,
  output logic [WIDTH-1:0] demux5_y0,
  output logic [WIDTH-1:0] demux5_y1,
  output logic [WIDTH-1:0] demux5_y2,
  output logic [WIDTH-1:0] demux5_y3,
  output logic [WIDTH-1:0] demux5_y4,
  output logic [4:0]       demux5_v,
  input  logic [4:0]       demux5_ack,
  output logic [2:0]       demux5_cnt,
  output logic             demux5_err
);

  localparam int NSLOT = 5;

  logic [WIDTH-1:0] slot_q [NSLOT];
  logic [4:0]       v_q;
  logic [2:0]       cnt_q;
  logic             err_q;

  logic             sel_legal;
  logic [4:0]       sel_oh;
  logic             xfer;
  logic [4:0]       wr_oh;
  logic [4:0]       v_next;
  logic [2:0]       cnt_next;
  logic             err_next;

  // Decode the select to one-hot so illegal codes never index past slot 4.
  assign sel_legal = (demux5_s < 3'd5);
  assign sel_oh    = sel_legal ? (5'b00001 << demux5_s) : 5'b00000;

  // A slot accepts when empty or being drained this same cycle; illegal codes
  // are always accepted so the producer never deadlocks on a bad select.
  assign demux5_ready = !sel_legal || (|(sel_oh & (~v_q | demux5_ack)));
  assign xfer         = demux5_valid && demux5_ready;
  assign wr_oh        = xfer ? sel_oh : 5'b00000;

  // Ack clears before write sets, so a same-slot write+ack leaves the slot full.
  assign v_next   = (v_q & ~demux5_ack) | wr_oh;
  assign err_next = err_q || (xfer && !sel_legal);

  // NOTE: every variable assigned in always_comb gets a value before any
  // conditional path, otherwise synthesis infers a latch to hold it.
  always_comb begin
    cnt_next = 3'd0;
    for (int k = 0; k < NSLOT; k++) begin
      cnt_next = cnt_next + 3'(v_next[k]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q   <= 5'b00000;
      cnt_q <= 3'd0;
      err_q <= 1'b0;
      // NOTE: slot storage is deliberately reset here because the data
      // outputs must read zero after reset, not just the valid bits.
      for (int k = 0; k < NSLOT; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      v_q   <= v_next;
      cnt_q <= cnt_next;
      err_q <= err_next;
      for (int k = 0; k < NSLOT; k++) begin
        if (wr_oh[k]) begin
          slot_q[k] <= demux5_d;
        end
      end
    end
  end

  assign demux5_y0  = slot_q[0];
  assign demux5_y1  = slot_q[1];
  assign demux5_y2  = slot_q[2];
  assign demux5_y3  = slot_q[3];
  assign demux5_y4  = slot_q[4];
  assign demux5_v   = v_q;
  assign demux5_cnt = cnt_q;
  assign demux5_err = err_q;

endmodule

// File: tb/tb_demux5_buf.sv
// Directed bench for demux5_buf: a slot-level behavioural model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_demux5_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        demux5_valid;
  logic [31:0] demux5_d;
  logic [2:0]  demux5_s;
  logic        demux5_ready;
  logic [31:0] demux5_y0, demux5_y1, demux5_y2, demux5_y3, demux5_y4;
  logic [4:0]  demux5_v;
  logic [4:0]  demux5_ack;
  logic [2:0]  demux5_cnt;
  logic        demux5_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  demux5_buf #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .demux5_valid (demux5_valid),
    .demux5_d     (demux5_d),
    .demux5_s     (demux5_s),
    .demux5_ready (demux5_ready),
    .demux5_y0    (demux5_y0),
    .demux5_y1    (demux5_y1),
    .demux5_y2    (demux5_y2),
    .demux5_y3    (demux5_y3),
    .demux5_y4    (demux5_y4),
    .demux5_v     (demux5_v),
    .demux5_ack   (demux5_ack),
    .demux5_cnt   (demux5_cnt),
    .demux5_err   (demux5_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: five slots, each a word plus a full flag.
  logic [31:0] m_word [5];
  bit          m_full [5];
  bit          m_err;

  function automatic bit m_ready(input logic [2:0] s, input logic [4:0] ack);
    if (s > 3'd4) return 1'b1;
    return !m_full[s] || ack[s];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < 5; k++) if (m_full[k]) c++;
    return c;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 5; k++) begin
        m_word[k] = 32'd0;
        m_full[k] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      bit rdy;
      rdy = m_ready(demux5_s, demux5_ack);
      for (int k = 0; k < 5; k++) if (demux5_ack[k]) m_full[k] = 1'b0;
      if (demux5_valid && rdy) begin
        if (demux5_s <= 3'd4) begin
          m_word[demux5_s] = demux5_d;
          m_full[demux5_s] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [4:0] mv;
      for (int k = 0; k < 5; k++) mv[k] = m_full[k];
      check("ready", 32'(demux5_ready), 32'(m_ready(demux5_s, demux5_ack)));
      check("y0", demux5_y0, m_word[0]);
      check("y1", demux5_y1, m_word[1]);
      check("y2", demux5_y2, m_word[2]);
      check("y3", demux5_y3, m_word[3]);
      check("y4", demux5_y4, m_word[4]);
      check("v", 32'(demux5_v), 32'(mv));
      check("cnt", 32'(demux5_cnt), 32'(m_count()));
      check("err", 32'(demux5_err), 32'(m_err));
    end
  end

  task automatic drive(input logic rst, input logic vld, input logic [31:0] d,
                       input logic [2:0] s, input logic [4:0] ack);
    @(posedge clk);
    #1;
    reset        = rst;
    demux5_valid = vld;
    demux5_d     = d;
    demux5_s     = s;
    demux5_ack   = ack;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 32'd0, 3'd0, 5'b00000);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    demux5_valid = 1'b1;
    demux5_d     = 32'hFFFF_FFFF;
    demux5_s     = 3'd2;
    demux5_ack   = 5'b00000;

    // 1. Reset held two cycles with random inputs.
    drive(1'b0, 1'($urandom), $urandom, 3'($urandom_range(7)), 5'($urandom));
    cmp_en = 1'b1;
    drive(1'b0, 1'($urandom), $urandom, 3'($urandom_range(7)), 5'($urandom));
    idle();
    settle();
    check("rst_v", 32'(demux5_v), 32'h0);
    check("rst_cnt", 32'(demux5_cnt), 32'h0);
    check("rst_err", 32'(demux5_err), 32'h0);
    check("rst_y0", demux5_y0, 32'h0);
    check("rst_y4", demux5_y4, 32'h0);

    // 2. Steer to slot 3, then drain it.
    drive(1'b1, 1'b1, 32'hA5A5_0001, 3'd3, 5'b00000);
    settle();
    check("steer_ready", 32'(demux5_ready), 32'h1);
    check("steer_lat_v", 32'(demux5_v), 32'h0);
    idle();
    settle();
    check("steer_y3", demux5_y3, 32'hA5A5_0001);
    check("steer_v", 32'(demux5_v), 32'h08);
    check("steer_cnt", 32'(demux5_cnt), 32'h1);
    drive(1'b1, 1'b0, 32'd0, 3'd0, 5'b01000);
    idle();
    settle();
    check("drain_v", 32'(demux5_v), 32'h0);
    check("drain_cnt", 32'(demux5_cnt), 32'h0);
    check("drain_y3_kept", demux5_y3, 32'hA5A5_0001);

    // 3. Full slot stalls; same-cycle ack lets the new word in without a bubble.
    drive(1'b1, 1'b1, 32'h0000_1111, 3'd1, 5'b00000);
    idle();
    drive(1'b1, 1'b1, 32'h0000_2222, 3'd1, 5'b00000);
    settle();
    check("full_ready", 32'(demux5_ready), 32'h0);
    drive(1'b1, 1'b1, 32'h0000_2222, 3'd1, 5'b00000);
    settle();
    check("stall_y1", demux5_y1, 32'h0000_1111);
    drive(1'b1, 1'b1, 32'h0000_2222, 3'd1, 5'b00010);
    settle();
    check("ack_ready", 32'(demux5_ready), 32'h1);
    idle();
    settle();
    check("b2b_y1", demux5_y1, 32'h0000_2222);
    check("b2b_v", 32'(demux5_v), 32'h02);
    drive(1'b1, 1'b0, 32'd0, 3'd0, 5'b00010);

    // 4. Fill all five slots, then drain all in one cycle.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 32'(i + 1), 3'(i), 5'b00000);
    idle();
    settle();
    check("all_cnt", 32'(demux5_cnt), 32'h5);
    check("all_v", 32'(demux5_v), 32'h1F);
    check("all_y2", demux5_y2, 32'h3);
    check("all_y4", demux5_y4, 32'h5);
    drive(1'b1, 1'b0, 32'd0, 3'd0, 5'b11111);
    idle();
    settle();
    check("none_cnt", 32'(demux5_cnt), 32'h0);

    // 5. Illegal select is accepted, dropped, and sets a sticky error.
    drive(1'b1, 1'b1, 32'h0000_DEAD, 3'd6, 5'b00000);
    settle();
    check("ill_ready", 32'(demux5_ready), 32'h1);
    idle();
    settle();
    check("ill_err", 32'(demux5_err), 32'h1);
    check("ill_v", 32'(demux5_v), 32'h0);
    check("ill_y1", demux5_y1, 32'h2);

    // Write slot 2 while acking slot 0 in the same cycle: both take effect.
    drive(1'b1, 1'b1, 32'h0000_00A0, 3'd0, 5'b00000);
    drive(1'b1, 1'b1, 32'h0000_00A2, 3'd2, 5'b00001);
    idle();
    settle();
    check("jk_v", 32'(demux5_v), 32'h04);
    check("sticky_err", 32'(demux5_err), 32'h1);
    drive(1'b1, 1'b1, 32'h0000_00B0, 3'd0, 5'b00000);

    // 6. Reset in the same cycle as a write to slot 4.
    drive(1'b0, 1'b1, 32'h0000_0044, 3'd4, 5'b00000);
    idle();
    settle();
    check("mid_v", 32'(demux5_v), 32'h0);
    check("mid_y4", demux5_y4, 32'h0);
    check("mid_cnt", 32'(demux5_cnt), 32'h0);
    check("mid_err", 32'(demux5_err), 32'h0);
    idle();
    settle();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
